lcd_fetch: RTL

//  Screen fetch engine downstream of the blink. Walks the screen base file (SBR) per scanline and fetches glyph bytes from PB0-PB3 over the video address bus (va/vid_cdo) in non-Z80 slots.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_glyph_fx.sv | 36 +++
 rtl/lcd_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD screen fetch engine.
// Attribute layout, FSM encoding and glyph geometry.
package lcd_pkg;

  localparam int ATTR_CH8 = 0;
  localparam int ATTR_UND = 1;
  localparam int ATTR_GRY = 2;
  localparam int ATTR_FLS = 3;
  localparam int ATTR_REV = 4;
  localparam int ATTR_HRS = 5;

  localparam logic [8:0] LORES0_LIM = 9'h1C0;
  localparam logic [9:0] HIRES0_LIM = 10'h300;

  localparam logic [9:0] WID_LORES = 10'd6;
  localparam logic [9:0] WID_HIRES = 10'd8;

  localparam logic [1:0] Z80_SLOT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALO,
    ST_AHI,
    ST_FONT,
    ST_EMIT
  } lcd_state_e;

  // HRS together with REV marks an empty SBR slot
  function automatic logic null_entry(input logic [7:0] a);
    return a[ATTR_HRS] & a[ATTR_REV];
  endfunction

endpackage

// File: rtl/lcd_glyph_fx.sv
// Glyph attribute effects: underline, reverse, flash, grey.
// Pure combinational; lores output is left-justified.
module lcd_glyph_fx
  import lcd_pkg::*;
(
  input  logic [7:0] raw,
  input  logic       hrs,
  input  logic       und,
  input  logic       rev,
  input  logic       fls,
  input  logic       gry,
  input  logic [2:0] scan,
  input  logic       t_1s,
  input  logic       t_5ms,
  output logic [7:0] data,
  output logic       wid,
  output logic       grey
);

  logic [7:0] g;

  always_comb begin
    g = hrs ? raw : {2'b00, raw[5:0]};
    if (!hrs && und && scan == 3'd7)
      g = 8'h3F;
    if (rev)
      g = hrs ? ~g : {2'b00, ~g[5:0]};
    if (fls && !t_1s)
      g = 8'h00;
    data = hrs ? g : {g[5:0], 2'b00};
  end

  assign wid  = hrs;
  assign grey = gry & t_5ms;

endmodule

// File: rtl/lcd_fetch.sv
// Screen fetch engine: walks SBR per scanline, fetches glyph
// bytes in video slots and streams pixel bytes to scanout.
module lcd_fetch
  import lcd_pkg::*;
#(
  parameter int LINE_PIX = 640,
  parameter int MAX_COLS = 108,
  parameter int LINES    = 64
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic [1:0]  clkcnt,
  input  logic        lcdon,
  input  logic [12:0] pb0w,
  input  logic [9:0]  pb1w,
  input  logic [8:0]  pb2w,
  input  logic [10:0] pb3w,
  input  logic [10:0] sbrw,
  input  logic        t_1s,
  input  logic        t_5ms,
  output logic [21:0] va,
  input  logic [7:0]  vid_cdo,
  output logic [7:0]  pix_data,
  output logic        pix_wid,
  output logic        pix_grey,
  output logic        pix_sol,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam logic [9:0] LINE_PIX_W = 10'(LINE_PIX);
  localparam logic [6:0] MAX_COLS_W = 7'(MAX_COLS);
  localparam logic [5:0] LAST_LINE  = 6'(LINES - 1);

  lcd_state_e  state;
  logic [5:0]  line;
  logic [6:0]  col;
  logic [9:0]  width;
  logic [7:0]  ch;
  logic [5:0]  attr;
  logic        first;

  logic [12:0] pb0_l;
  logic [9:0]  pb1_l;
  logic [8:0]  pb2_l;
  logic [10:0] pb3_l;
  logic [10:0] sbr_l;

  logic        go;
  logic [2:0]  scan;
  logic        hrs;
  logic [8:0]  idx9;
  logic [9:0]  idx10;
  logic [21:0] fa_lo0;
  logic [21:0] fa_lo1;
  logic [21:0] fa_hi0;
  logic [21:0] fa_hi1;
  logic [21:0] font_va;

  logic [9:0]  step;
  logic [9:0]  width_nx;
  logic [6:0]  col_nx;
  logic [5:0]  line_nx;
  logic        eol;
  logic        adv;

  logic [7:0]  fx_data;
  logic        fx_wid;
  logic        fx_grey;

  assign go    = (clkcnt != Z80_SLOT);
  assign scan  = line[2:0];
  assign hrs   = attr[ATTR_HRS];
  assign idx9  = {attr[ATTR_CH8], ch};
  assign idx10 = {attr[ATTR_UND], attr[ATTR_CH8], ch};

  assign fa_lo0 = {pb0_l, 9'b0}  + {13'b0, idx9[5:0], scan};
  assign fa_lo1 = {pb1_l, 12'b0} + {10'b0, idx9, scan};
  assign fa_hi0 = {pb2_l, 13'b0} + {9'b0, idx10, scan};
  assign fa_hi1 = {pb3_l, 11'b0} + {11'b0, idx10[7:0], scan};

  always_comb begin
    font_va = '0;
    unique case (1'b1)
      !hrs && (idx9 >= LORES0_LIM):  font_va = fa_lo0;
      !hrs && (idx9 < LORES0_LIM):   font_va = fa_lo1;
      hrs && (idx10 >= HIRES0_LIM):  font_va = fa_hi1;
      hrs && (idx10 < HIRES0_LIM):   font_va = fa_hi0;
    endcase
  end

  always_comb begin
    va = '0;
    unique case (state)
      ST_ALO, ST_AHI:
        va = {sbr_l, line[5:3], col, (state == ST_AHI)};
      ST_FONT, ST_EMIT:
        va = font_va;
      default:
        va = '0;
    endcase
  end

  assign step     = pix_wid ? WID_HIRES : WID_LORES;
  assign width_nx = width + ((state == ST_EMIT) ? step : 10'd0);
  assign col_nx   = col + 7'd1;
  assign line_nx  = (line == LAST_LINE) ? 6'd0 : line + 6'd1;
  assign eol      = (width_nx >= LINE_PIX_W) ||
                    (col_nx == MAX_COLS_W);

  // a character slot is finished: emitted byte taken or NULL skipped
  assign adv = ((state == ST_AHI) && go && null_entry(vid_cdo)) ||
               ((state == ST_EMIT) && pix_ready);

  lcd_glyph_fx u_fx (
    .raw   (vid_cdo),
    .hrs   (attr[ATTR_HRS]),
    .und   (attr[ATTR_UND]),
    .rev   (attr[ATTR_REV]),
    .fls   (attr[ATTR_FLS]),
    .gry   (attr[ATTR_GRY]),
    .scan  (scan),
    .t_1s  (t_1s),
    .t_5ms (t_5ms),
    .data  (fx_data),
    .wid   (fx_wid),
    .grey  (fx_grey)
  );

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state     <= ST_IDLE;
      line      <= '0;
      col       <= '0;
      width     <= '0;
      ch        <= '0;
      attr      <= '0;
      first     <= 1'b0;
      pb0_l     <= '0;
      pb1_l     <= '0;
      pb2_l     <= '0;
      pb3_l     <= '0;
      sbr_l     <= '0;
      pix_data  <= '0;
      pix_wid   <= 1'b0;
      pix_grey  <= 1'b0;
      pix_sol   <= 1'b0;
      pix_sof   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (lcdon) begin
            state <= ST_ALO;
            col   <= '0;
            width <= '0;
            first <= 1'b1;
            pb0_l <= pb0w;
            pb1_l <= pb1w;
            pb2_l <= pb2w;
            pb3_l <= pb3w;
            sbr_l <= sbrw;
          end
        end
        ST_ALO: begin
          if (go) begin
            ch    <= vid_cdo;
            state <= ST_AHI;
          end
        end
        ST_AHI: begin
          if (go) begin
            attr  <= vid_cdo[5:0];
            state <= ST_FONT;
          end
        end
        ST_FONT: begin
          if (go) begin
            pix_data  <= fx_data;
            pix_wid   <= fx_wid;
            pix_grey  <= fx_grey;
            pix_sol   <= first;
            pix_sof   <= first && (line == 6'd0);
            pix_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_sol   <= 1'b0;
            pix_sof   <= 1'b0;
            first     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (adv) begin
        if (!lcdon) begin
          state <= ST_IDLE;
          line  <= '0;
          col   <= '0;
          width <= '0;
        end else if (eol) begin
          state <= ST_ALO;
          col   <= '0;
          width <= '0;
          line  <= line_nx;
          first <= 1'b1;
          pb0_l <= pb0w;
          pb1_l <= pb1w;
          pb2_l <= pb2w;
          pb3_l <= pb3w;
          sbr_l <= sbrw;
        end else begin
          state <= ST_ALO;
          col   <= col_nx;
          width <= width_nx;
        end
      end
    end
  end

endmodule
